pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, operand forwarding and halt/drain sequencing for a
// five-stage in-order pipeline, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int NB_REG      = 5,
    parameter int DRAIN_DEPTH = 4,
    parameter int NB_CNT      = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              en_pipeline_i,
    input  logic              restart_i,
    input  logic [NB_REG-1:0] dec_rs_i,
    input  logic [NB_REG-1:0] dec_rt_i,
    input  logic              dec_uses_rs_i,
    input  logic              dec_uses_rt_i,
    input  logic              dec_is_branch_i,
    input  logic              dec_halt_i,
    input  logic              branch_taken_i,
    input  logic [NB_REG-1:0] ex_rs_i,
    input  logic [NB_REG-1:0] ex_rt_i,
    input  logic [NB_REG-1:0] ex_rd_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [NB_REG-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    input  logic [NB_REG-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    output logic              pc_write_o,
    output logic              if_dec_write_o,
    output logic              if_dec_flush_o,
    output logic              dec_ex_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              dec_fwd_a_o,
    output logic              dec_fwd_b_o,
    output logic [1:0]        state_o,
    output logic              halted_o,
    output logic [NB_CNT-1:0] stall_count_o
);

    localparam int NB_DRN = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [NB_DRN-1:0] drn_cnt, drn_cnt_nxt;
    logic              halted_q;
    logic [NB_CNT-1:0] stall_cnt;

    logic load_use, branch_hazard, stall;

    // Register 0 is hardwired to zero, so it never aliases a producer.
    function automatic logic hit(input logic [NB_REG-1:0] a, input logic [NB_REG-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [NB_REG-1:0] src);
        if (mem_reg_write_i && hit(mem_rd_i, src))
            return 2'b01;
        else if (wb_reg_write_i && hit(wb_rd_i, src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd_a_o = fwd_sel(ex_rs_i);
    assign fwd_b_o = fwd_sel(ex_rt_i);

    assign dec_fwd_a_o = dec_is_branch_i && mem_reg_write_i && !mem_mem_read_i && hit(mem_rd_i, dec_rs_i);
    assign dec_fwd_b_o = dec_is_branch_i && mem_reg_write_i && !mem_mem_read_i && hit(mem_rd_i, dec_rt_i);

    logic ex_rd_used, mem_rd_used;
    assign ex_rd_used  = (dec_uses_rs_i && hit(ex_rd_i, dec_rs_i)) ||
                         (dec_uses_rt_i && hit(ex_rd_i, dec_rt_i));
    assign mem_rd_used = (dec_uses_rs_i && hit(mem_rd_i, dec_rs_i)) ||
                         (dec_uses_rt_i && hit(mem_rd_i, dec_rt_i));

    assign load_use      = ex_mem_read_i && ex_rd_used;
    // A branch compares in decode, so it must wait for an EX result or a pending load in MEM.
    assign branch_hazard = dec_is_branch_i &&
                           ((ex_reg_write_i && ex_rd_used) || (mem_mem_read_i && mem_rd_used));
    assign stall         = (state == RUN) && (load_use || branch_hazard);

    always_comb begin
        state_nxt       = state;
        drn_cnt_nxt     = drn_cnt;
        pc_write_o      = 1'b0;
        if_dec_write_o  = 1'b0;
        if_dec_flush_o  = 1'b0;
        dec_ex_bubble_o = 1'b1;
        case (state)
            RUN: begin
                if (!stall) begin
                    pc_write_o      = 1'b1;
                    if_dec_write_o  = 1'b1;
                    dec_ex_bubble_o = 1'b0;
                    if_dec_flush_o  = branch_taken_i;
                    if (dec_halt_i) begin
                        state_nxt   = DRAIN;
                        drn_cnt_nxt = NB_DRN'(DRAIN_DEPTH - 1);
                    end
                end
            end
            DRAIN: begin
                if (drn_cnt == '0)
                    state_nxt = HALTED;
                else
                    drn_cnt_nxt = drn_cnt - 1'b1;
            end
            HALTED: begin
                if (restart_i)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= RUN;
            drn_cnt   <= '0;
            halted_q  <= 1'b0;
            stall_cnt <= '0;
        end else if (en_pipeline_i) begin
            state    <= state_nxt;
            drn_cnt  <= drn_cnt_nxt;
            halted_q <= (state_nxt == HALTED);
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign state_o       = state;
    assign halted_o      = halted_q;
    assign stall_count_o = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; a second instance with a
// 3-bit stall counter exercises saturation on the same stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clock_i = 1'b0;
    logic       reset_i, en_pipeline_i, restart_i;
    logic [4:0] dec_rs_i, dec_rt_i, ex_rs_i, ex_rt_i, ex_rd_i, mem_rd_i, wb_rd_i;
    logic       dec_uses_rs_i, dec_uses_rt_i, dec_is_branch_i, dec_halt_i, branch_taken_i;
    logic       ex_reg_write_i, ex_mem_read_i, mem_reg_write_i, mem_mem_read_i, wb_reg_write_i;
    logic       pc_write_o, if_dec_write_o, if_dec_flush_o, dec_ex_bubble_o;
    logic [1:0] fwd_a_o, fwd_b_o, state_o;
    logic       dec_fwd_a_o, dec_fwd_b_o, halted_o;
    logic [15:0] stall_count_o;

    logic       s_pc_write, s_if_dec_write, s_flush, s_bubble, s_dfa, s_dfb, s_halted;
    logic [1:0] s_fwd_a, s_fwd_b, s_state;
    logic [2:0] s_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    always #5 clock_i = ~clock_i;

    pipeline_hazard_ctrl #(.NB_REG(5), .DRAIN_DEPTH(4), .NB_CNT(16)) u_dut (
        .clock_i(clock_i), .reset_i(reset_i), .en_pipeline_i(en_pipeline_i), .restart_i(restart_i),
        .dec_rs_i(dec_rs_i), .dec_rt_i(dec_rt_i), .dec_uses_rs_i(dec_uses_rs_i), .dec_uses_rt_i(dec_uses_rt_i),
        .dec_is_branch_i(dec_is_branch_i), .dec_halt_i(dec_halt_i), .branch_taken_i(branch_taken_i),
        .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
        .ex_mem_read_i(ex_mem_read_i), .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_mem_read_i(mem_mem_read_i), .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
        .pc_write_o(pc_write_o), .if_dec_write_o(if_dec_write_o), .if_dec_flush_o(if_dec_flush_o),
        .dec_ex_bubble_o(dec_ex_bubble_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .dec_fwd_a_o(dec_fwd_a_o), .dec_fwd_b_o(dec_fwd_b_o), .state_o(state_o),
        .halted_o(halted_o), .stall_count_o(stall_count_o)
    );

    pipeline_hazard_ctrl #(.NB_REG(5), .DRAIN_DEPTH(4), .NB_CNT(3)) u_sat (
        .clock_i(clock_i), .reset_i(reset_i), .en_pipeline_i(en_pipeline_i), .restart_i(restart_i),
        .dec_rs_i(dec_rs_i), .dec_rt_i(dec_rt_i), .dec_uses_rs_i(dec_uses_rs_i), .dec_uses_rt_i(dec_uses_rt_i),
        .dec_is_branch_i(dec_is_branch_i), .dec_halt_i(dec_halt_i), .branch_taken_i(branch_taken_i),
        .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
        .ex_mem_read_i(ex_mem_read_i), .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_mem_read_i(mem_mem_read_i), .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
        .pc_write_o(s_pc_write), .if_dec_write_o(s_if_dec_write), .if_dec_flush_o(s_flush),
        .dec_ex_bubble_o(s_bubble), .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b),
        .dec_fwd_a_o(s_dfa), .dec_fwd_b_o(s_dfb), .state_o(s_state),
        .halted_o(s_halted), .stall_count_o(s_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic clear_in();
        restart_i = 0; dec_rs_i = 0; dec_rt_i = 0; dec_uses_rs_i = 0; dec_uses_rt_i = 0;
        dec_is_branch_i = 0; dec_halt_i = 0; branch_taken_i = 0;
        ex_rs_i = 0; ex_rt_i = 0; ex_rd_i = 0; ex_reg_write_i = 0; ex_mem_read_i = 0;
        mem_rd_i = 0; mem_reg_write_i = 0; mem_mem_read_i = 0; wb_rd_i = 0; wb_reg_write_i = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read_i = 1; ex_rd_i = 5; dec_rt_i = 5; dec_uses_rt_i = 1;
    endtask

    initial begin
        clear_in();
        reset_i = 1; en_pipeline_i = 1;
        tick(); tick();
        reset_i = 0;
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_cnt", int'(stall_count_o), 0);
        chk("rst_pc_write", int'(pc_write_o), 1);
        chk("rst_ifd_write", int'(if_dec_write_o), 1);
        chk("rst_flush", int'(if_dec_flush_o), 0);
        chk("rst_bubble", int'(dec_ex_bubble_o), 0);
        chk("rst_fwd", int'({fwd_a_o, fwd_b_o}), 0);
        chk("rst_dfwd", int'({dec_fwd_a_o, dec_fwd_b_o}), 0);
        chk("rst_halted", int'(halted_o), 0);

        // EX forwarding priority
        ex_rs_i = 3; mem_rd_i = 3; wb_rd_i = 3; mem_reg_write_i = 1; wb_reg_write_i = 1; #1;
        chk("fwd_mem_prio", int'(fwd_a_o), 1);
        mem_reg_write_i = 0; #1;
        chk("fwd_wb", int'(fwd_a_o), 2);
        ex_rs_i = 0; mem_rd_i = 0; wb_rd_i = 0; mem_reg_write_i = 1; #1;
        chk("fwd_r0", int'(fwd_a_o), 0);
        ex_rt_i = 4; wb_rd_i = 4; en_pipeline_i = 0; #1;
        chk("fwd_b_wb_noen", int'(fwd_b_o), 2);
        en_pipeline_i = 1;
        clear_in(); #1;

        // Load-use: one stalled cycle
        set_load_use(); dec_uses_rt_i = 0; #1;
        chk("lu_unused_src", int'(pc_write_o), 1);
        dec_uses_rt_i = 1; #1;
        chk("lu_pc_write", int'(pc_write_o), 0);
        chk("lu_bubble", int'(dec_ex_bubble_o), 1);
        chk("lu_ifd_write", int'(if_dec_write_o), 0);
        tick();
        clear_in(); #1;
        chk("lu_release", int'(pc_write_o), 1);
        chk("lu_cnt", int'(stall_count_o), 1);

        // Branch hazards
        dec_is_branch_i = 1; dec_rs_i = 7; dec_uses_rs_i = 1; ex_rd_i = 7; ex_reg_write_i = 1; #1;
        chk("br_ex_stall", int'(pc_write_o), 0);
        tick();
        chk("br_cnt", int'(stall_count_o), 2);
        ex_rd_i = 0; ex_reg_write_i = 0; mem_rd_i = 7; mem_reg_write_i = 1; #1;
        chk("br_dfwd_a", int'(dec_fwd_a_o), 1);
        chk("br_nostall", int'(pc_write_o), 1);
        branch_taken_i = 1; #1;
        chk("br_flush", int'(if_dec_flush_o), 1);
        mem_mem_read_i = 1; #1;
        chk("br_load_stall", int'(pc_write_o), 0);
        chk("br_load_nofwd", int'(dec_fwd_a_o), 0);
        chk("br_load_noflush", int'(if_dec_flush_o), 0);
        tick();
        clear_in(); #1;
        chk("br_cnt2", int'(stall_count_o), 3);

        // Stall beats flush and halt
        set_load_use(); dec_halt_i = 1; branch_taken_i = 1; #1;
        chk("prio_flush", int'(if_dec_flush_o), 0);
        chk("prio_pc", int'(pc_write_o), 0);
        tick();
        chk("prio_state", int'(state_o), 0);
        chk("prio_cnt", int'(stall_count_o), 4);
        clear_in(); #1;

        // Plain drain; restart is ignored while draining
        dec_halt_i = 1;
        tick();
        dec_halt_i = 0; restart_i = 1; #1;
        chk("drn_enter", int'(state_o), 1);
        chk("drn_pc", int'(pc_write_o), 0);
        chk("drn_bubble", int'(dec_ex_bubble_o), 1);
        tick();
        restart_i = 0;
        chk("drn_restart_ign", int'(state_o), 1);
        tick(); tick();
        chk("drn_last", int'(state_o), 1);
        tick();
        chk("drn_halted_st", int'(state_o), 2);
        chk("drn_halted", int'(halted_o), 1);
        chk("hlt_pc", int'(pc_write_o), 0);
        chk("hlt_ifd", int'(if_dec_write_o), 0);
        chk("hlt_bubble", int'(dec_ex_bubble_o), 1);
        restart_i = 1; en_pipeline_i = 0;
        tick();
        chk("hlt_noen_hold", int'(state_o), 2);
        en_pipeline_i = 1;
        tick();
        restart_i = 0; #1;
        chk("restart_run", int'(state_o), 0);
        chk("restart_halted", int'(halted_o), 0);

        // Drain with three disabled edges mid-way
        dec_halt_i = 1;
        tick();
        dec_halt_i = 0;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            en_pipeline_i = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            tick();
            cyc = i;
            if (halted_o) break;
        end
        en_pipeline_i = 1;
        chk("drn_ext_cycles", cyc, 7);

        // Reset mid-drain
        restart_i = 1;
        tick();
        restart_i = 0; dec_halt_i = 1;
        tick();
        dec_halt_i = 0;
        tick();
        chk("rst_mid_pre", int'(state_o), 1);
        reset_i = 1;
        tick();
        reset_i = 0;
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_cnt", int'(stall_count_o), 0);

        // Disabled edge holds the counter, then saturation on the 3-bit copy
        set_load_use(); en_pipeline_i = 0;
        tick();
        chk("noen_cnt_hold", int'(stall_count_o), 0);
        en_pipeline_i = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("cnt_10", int'(stall_count_o), 10);
        chk("sat_7", int'(s_cnt), 7);
        tick(); tick();
        chk("sat_hold", int'(s_cnt), 7);
        clear_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
